// File: rtl/ts_pkg.sv
// Shared constants and types for the TS deserializer (ts_deser_n) and its buffer.
package ts_pkg;

   localparam logic [7:0] TS_SYNC_BYTE = 8'h47;
   localparam int         PKT_LEN_188  = 188;
   localparam int         PKT_LEN_204  = 204;

   // Buffer word layout: {sop, eop, data[7:0]}
   localparam int TS_FIFO_W = 10;
   localparam int SOP_BIT   = 9;
   localparam int EOP_BIT   = 8;

   typedef enum logic [1:0] {
      ST_HUNT   = 2'd0,
      ST_VERIFY = 2'd1,
      ST_LOCK   = 2'd2
   } ts_state_t;

endpackage

// File: rtl/ts_sfifo.sv
// Synchronous first-word-fall-through FIFO: the head word is visible on
// rdata_o whenever empty_o is low. A push while full is accepted only when
// a pop happens in the same cycle.
module ts_sfifo
   import ts_pkg::*;
#(
   parameter int WIDTH     = TS_FIFO_W,
   parameter int DEPTH_BIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int DEPTH = 2 ** DEPTH_BIT;

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [DEPTH_BIT-1:0] wr_ptr_q;
   logic [DEPTH_BIT-1:0] rd_ptr_q;
   logic [DEPTH_BIT:0]   cnt_q;
   logic                 do_push;
   logic                 do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == (DEPTH_BIT+1)'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];

   // storage array
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else if (do_push) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + (DEPTH_BIT)'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + (DEPTH_BIT)'(1);
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + (DEPTH_BIT+1)'(1);
            2'b01:   cnt_q <= cnt_q - (DEPTH_BIT+1)'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

endmodule

// File: rtl/ts_deser_n.sv
// MPEG-TS lane deserializer with sync-byte lock and whole-packet output buffer.
// Optional macro TS_ERR_CNT_EN adds err_cnt[15:0], a saturating count of
// LOCK->HUNT transitions.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_HUNT   | searching for a sync-flagged 8'h47 byte
// ST_VERIFY | sync found; counting consecutive good headers up to LOCK_CNT
// ST_LOCK   | locked; bytes of enabled packets are written to the buffer
//
// Pipeline: input stage 1 -> input stage 2 -> byte assembly -> FSM/write
// decision -> buffer write. A byte whose last beat is sampled at edge N is
// visible at the output after edge N+4 when the buffer is empty.
module ts_deser_n
   import ts_pkg::*;
#(
   parameter int IN_WIDTH       = 1,
   parameter int PKT_LEN        = PKT_LEN_188,
   parameter int LSB_FIRST      = 1,
   parameter int LOCK_CNT       = 3,
   parameter int FIFO_DEPTH_BIT = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [IN_WIDTH-1:0] ts_i_data,
   input  logic                ts_i_sync,
   input  logic                ts_i_valid,
   output logic [7:0]          ts_o_data,
   output logic                ts_o_sop,
   output logic                ts_o_eop,
   output logic                ts_o_valid,
   input  logic                ts_o_ready,
   output logic                lock,
   output logic                ovf
`ifdef TS_ERR_CNT_EN
   ,output logic [15:0]        err_cnt
`endif
);

   localparam int BEATS  = 8 / IN_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int IDX_W  = $clog2(PKT_LEN);
   localparam int GOOD_W = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;

   // input pipeline
   logic [IN_WIDTH-1:0] s1_data_q, s2_data_q;
   logic                s1_sync_q, s2_sync_q;
   logic                s1_vld_q,  s2_vld_q;

   // byte assembly
   logic [BEAT_W-1:0]   beat_q;
   logic [BEAT_W-1:0]   pos;
   logic [7:0]          sh_q;
   logic [7:0]          asm_nxt;
   logic                asm_done;
   logic                sync_pend_q;
   logic                asm_vld_q;
   logic                asm_sync_q;
   logic [7:0]          asm_byte_q;

   // framing FSM
   ts_state_t           state_q;
   logic [GOOD_W-1:0]   good_q;
   logic [IDX_W-1:0]    idx_q;
   logic [IDX_W-1:0]    cur_idx;
   logic                hdr_ok;
   logic                at_hdr;
   logic                last_b;
   logic                lose_hdr;
   logic                lock_lost;
   logic                wr_q;
   logic [TS_FIFO_W-1:0] wr_word_q;

   // buffer write stage
   logic                drop_pkt_q;
   logic                ovf_q;
   logic                wr_try;
   logic                wr_ovf;
   logic                fifo_push;
   logic                fifo_pop;
   logic                fifo_empty;
   logic                fifo_full;
   logic [TS_FIFO_W-1:0] fifo_rdata;

   // two-stage input register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_data_q <= '0;
         s1_sync_q <= 1'b0;
         s1_vld_q  <= 1'b0;
         s2_data_q <= '0;
         s2_sync_q <= 1'b0;
         s2_vld_q  <= 1'b0;
      end else begin
         s1_data_q <= ts_i_data;
         s1_sync_q <= ts_i_sync;
         s1_vld_q  <= ts_i_valid;
         s2_data_q <= s1_data_q;
         s2_sync_q <= s1_sync_q;
         s2_vld_q  <= s1_vld_q;
      end
   end

   // place the current beat into the partial byte; a sync beat restarts at beat 0
   always_comb begin
      pos      = s2_sync_q ? '0 : beat_q;
      asm_nxt  = (pos == '0) ? 8'h00 : sh_q;
      for (int k = 0; k < BEATS; k++) begin
         if (pos == (BEAT_W)'(k)) begin
            if (LSB_FIRST != 0) asm_nxt[k*IN_WIDTH +: IN_WIDTH] = s2_data_q;
            else                asm_nxt[(BEATS-1-k)*IN_WIDTH +: IN_WIDTH] = s2_data_q;
         end
      end
      asm_done = (pos == (BEAT_W)'(BEATS-1));
   end

   // byte assembly registers; emits one byte with its sync flag per BEATS beats
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         beat_q      <= '0;
         sh_q        <= '0;
         sync_pend_q <= 1'b0;
         asm_vld_q   <= 1'b0;
         asm_sync_q  <= 1'b0;
         asm_byte_q  <= '0;
      end else begin
         asm_vld_q <= 1'b0;
         if (s2_vld_q) begin
            sh_q <= asm_nxt;
            if (pos == '0) sync_pend_q <= s2_sync_q;
            if (asm_done) begin
               beat_q     <= '0;
               asm_vld_q  <= 1'b1;
               asm_byte_q <= asm_nxt;
               asm_sync_q <= (pos == '0) ? s2_sync_q : sync_pend_q;
            end else begin
               beat_q <= pos + (BEAT_W)'(1);
            end
         end
      end
   end

   // header qualification against the expected packet position
   always_comb begin
      cur_idx   = asm_sync_q ? '0 : idx_q;
      hdr_ok    = asm_sync_q && (asm_byte_q == TS_SYNC_BYTE);
      at_hdr    = (idx_q == '0);
      last_b    = (cur_idx == (IDX_W)'(PKT_LEN - 1));
      lose_hdr  = (at_hdr && !hdr_ok) || (!at_hdr && asm_sync_q);
      lock_lost = asm_vld_q && (state_q == ST_LOCK) && lose_hdr;
   end

   // framing FSM with byte index; bytes are written only while LOCK holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_HUNT;
         good_q    <= '0;
         idx_q     <= '0;
         wr_q      <= 1'b0;
         wr_word_q <= '0;
      end else begin
         wr_q <= 1'b0;
         if (asm_vld_q) begin
            idx_q     <= last_b ? '0 : cur_idx + (IDX_W)'(1);
            wr_word_q <= {(cur_idx == '0), last_b, asm_byte_q};
            case (state_q)
               ST_HUNT: begin
                  if (hdr_ok) begin
                     good_q <= (GOOD_W)'(1);
                     if (LOCK_CNT <= 1) begin
                        state_q <= ST_LOCK;
                        wr_q    <= 1'b1;
                     end else begin
                        state_q <= ST_VERIFY;
                     end
                  end
               end
               ST_VERIFY: begin
                  if (lose_hdr) begin
                     state_q <= ST_HUNT;
                     good_q  <= '0;
                  end else if (at_hdr) begin
                     if ((int'(good_q) + 1) >= LOCK_CNT) begin
                        state_q <= ST_LOCK;
                        wr_q    <= 1'b1;
                     end else begin
                        good_q <= good_q + (GOOD_W)'(1);
                     end
                  end
               end
               ST_LOCK: begin
                  if (lose_hdr) begin
                     state_q <= ST_HUNT;
                     good_q  <= '0;
                  end else begin
                     wr_q <= 1'b1;
                  end
               end
               default: begin
                  state_q <= ST_HUNT;
                  good_q  <= '0;
               end
            endcase
         end
      end
   end

   assign lock = (state_q == ST_LOCK);

   // a packet that overflowed stays blocked until the next sop arrives
   assign fifo_pop  = ts_o_valid && ts_o_ready;
   assign wr_try    = wr_q && !(drop_pkt_q && !wr_word_q[SOP_BIT]);
   assign fifo_push = wr_try && (!fifo_full || fifo_pop);
   assign wr_ovf    = wr_try && fifo_full && !fifo_pop;

   // overflow bookkeeping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_pkt_q <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         if (wr_ovf) begin
            drop_pkt_q <= 1'b1;
            ovf_q      <= 1'b1;
         end else if (wr_q && wr_word_q[SOP_BIT]) begin
            drop_pkt_q <= 1'b0;
         end
      end
   end

   assign ovf = ovf_q;

   ts_sfifo #(
      .WIDTH     (TS_FIFO_W),
      .DEPTH_BIT (FIFO_DEPTH_BIT)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (fifo_push),
      .wdata_i (wr_word_q),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // outputs read as zero whenever nothing is buffered
   assign ts_o_valid = !fifo_empty;
   assign {ts_o_sop, ts_o_eop, ts_o_data} = fifo_empty ? '0 : fifo_rdata;

`ifdef TS_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   // saturating count of lock losses
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (lock_lost && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   logic unused_lock_lost;
   assign unused_lock_lost = lock_lost;
`endif

endmodule

// File: doc/ts_deser_n.md
TS_DESER_N -- requirements
Module: ts_deser_n

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 1, input lane count per beat, legal values 1/2/4/8.
REQ-002 SHALL have parameter PKT_LEN, default 188, bytes per TS packet, legal values 188/204.
REQ-003 SHALL have parameter LSB_FIRST, default 1; 1 means the first received beat lands in byte bits [IN_WIDTH-1:0].
REQ-004 SHALL have parameter LOCK_CNT, default 3, consecutive good sync bytes required for lock.
REQ-005 SHALL have parameter FIFO_DEPTH_BIT, default 4, log2 of output buffer depth.
REQ-006 SHALL have port clk input 1, the single clock.
REQ-007 SHALL have port rst_n input 1; reset is asynchronous and active-low.
REQ-008 SHALL have port ts_i_data input IN_WIDTH, TS lanes.
REQ-009 SHALL have port ts_i_sync input 1, marks the first beat of a packet.
REQ-010 SHALL have port ts_i_valid input 1, beat qualifier.
REQ-011 SHALL have ports ts_o_data output 8, ts_o_sop output 1 and ts_o_eop output 1, carrying the output byte and its first/last-byte flags.
REQ-012 SHALL have ports ts_o_valid output 1 and ts_o_ready input 1, forming the output handshake.
REQ-013 SHALL have port lock output 1, high while state is LOCK.
REQ-014 SHALL have port ovf output 1, sticky buffer-overflow flag.

Function
REQ-015 SHALL register ts_i_data/sync/valid through two stages before use.
REQ-016 SHALL complete a byte every 8/IN_WIDTH valid beats; a sync beat restarts assembly at beat 0, discarding any partial byte.
REQ-017 SHALL keep a byte index 0..PKT_LEN-1 that wraps to 0 after PKT_LEN-1 and is forced to 0 by a sync-flagged byte.
REQ-018 SHALL implement FSM HUNT/VERIFY/LOCK; in HUNT, a sync-flagged byte equal to 8'h47 moves to VERIFY with good count 1.
REQ-019 SHALL, in VERIFY at index 0, treat a sync-flagged byte of 8'h47 as good; on reaching LOCK_CNT it moves to LOCK, and on any other value it returns to HUNT.
REQ-020 SHALL, in LOCK, return to HUNT on a non-8'h47 or unflagged byte at index 0, or on a sync at index != 0; a sync at index != 0 in VERIFY also returns to HUNT.
REQ-021 SHALL write only whole packets: a packet is enabled at its index-0 byte if state is LOCK after that byte's evaluation; the first locked packet is the one whose header completes the LOCK_CNT count.
REQ-022 SHALL store {sop,eop,data} per byte; sop is set at index 0 and eop at index PKT_LEN-1.
REQ-023 SHALL, on loss of lock mid-packet, stop writes immediately; the truncated packet carries no eop.
REQ-024 SHALL provide a first-word-fall-through output: ts_o_valid = buffer not empty, and pop on ts_o_valid&ts_o_ready.
REQ-025 SHALL set latency so that, with the buffer empty, the byte completed by a beat sampled at edge N is valid after edge N+4.
REQ-026 SHALL, on a write while full, drop the byte, set ovf, and suppress the rest of that packet; a simultaneous pop makes the write legal.
REQ-027 SHALL hold ts_o_data/sop/eop stable while ts_o_valid=1 and ts_o_ready=0.

Reset
REQ-028 SHALL, while rst_n=0, clear all registers: FSM to HUNT, buffer emptied, index 0, and ts_o_valid/sop/eop/data, lock and ovf all 0.
REQ-029 SHALL, on reset mid-packet, discard all buffered bytes; after release, output resumes only after a fresh lock.

Configuration
REQ-030 SHALL, with macro TS_ERR_CNT_EN defined, add output err_cnt [15:0] that counts LOCK->HUNT transitions, saturates at 16'hFFFF and resets to 0.
REQ-031 SHALL, without TS_ERR_CNT_EN, have no err_cnt port or counter logic; all other behaviour is identical.

Structure
REQ-032 SHALL place TS_SYNC_BYTE (8'h47), the FSM state typedef and the PKT_LEN_188/PKT_LEN_204 constants in shared package ts_pkg.
REQ-033 SHALL implement the buffer as sub-module ts_sfifo: synchronous FWFT, width 10, depth 2**FIFO_DEPTH_BIT.

Verification
REQ-034 SHALL cover: IN_WIDTH=1, LSB_FIRST=1, 4 clean 188-byte packets -> lock rises at the 3rd header, and packets 3-4 emerge with sop on 8'h47 and eop on byte 187.
REQ-035 SHALL cover: IN_WIDTH=8, header 8'h46 in locked stream -> lock falls at that header, no bytes written until relock, and err_cnt increments by 1 (TS_ERR_CNT_EN).
REQ-036 SHALL cover: sync pulse at index 90 while locked -> HUNT, writes stop after byte 89, and the next output packet starts with sop.
REQ-037 SHALL cover: ts_o_ready=0 for 40 cycles, FIFO_DEPTH_BIT=4 -> ovf=1, 16 bytes held intact, remainder of that packet dropped, and the next packet complete.
REQ-038 SHALL cover: IN_WIDTH=4, LSB_FIRST=0, beats 4'h4 then 4'h7 -> byte 8'h47, and output valid 4 edges after the second beat.
REQ-039 SHALL cover: rst_n asserted mid-packet -> all outputs 0 at once, and none valid until 3 good headers after release.
